// File: rtl/ro_entropy_ctrl.sv
// Ring-oscillator TRNG sequencer: warms up the rings, samples their XOR at a fixed
// rate, packs bits into words on a valid/ready port and trips on repeated samples.

module ro_sync (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

module ro_entropy_ctrl #(
    parameter int NUM_RO        = 4,
    parameter int WARMUP_CYCLES = 64,
    parameter int SAMPLE_DIV    = 8,
    parameter int WORD_WIDTH    = 32,
    parameter int REP_LIMIT     = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic [NUM_RO-1:0]     ro_signal,
    output logic [NUM_RO-1:0]     ro_hold,
    output logic [WORD_WIDTH-1:0] rnd_data,
    output logic                  rnd_valid,
    input  logic                  rnd_ready,
    output logic                  busy,
    output logic                  health_fail
);
    localparam int WARM_W = $clog2(WARMUP_CYCLES + 1);
    localparam int DIV_W  = $clog2(SAMPLE_DIV);
    localparam int BIT_W  = $clog2(WORD_WIDTH);

    localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(WARMUP_CYCLES);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_WIDTH - 1);
    localparam logic [7:0]        REP_LIM   = 8'(REP_LIMIT);

    typedef enum logic [2:0] {IDLE, WARMUP, SAMPLE, HOLD, FAIL} state_t;

    state_t                state;
    logic [NUM_RO-1:0]     ro_sync_q;
    logic [WARM_W-1:0]     warm_cnt;
    logic [DIV_W-1:0]      div_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [7:0]            rep_cnt;
    logic                  last_bit;
    logic [WORD_WIDTH-1:0] shift;

    logic                  sample_bit;
    logic                  tick;
    logic                  handshake;
    logic [7:0]            rep_next;
    logic [WORD_WIDTH-1:0] word_next;

    for (genvar i = 0; i < NUM_RO; i++) begin : g_sync
        ro_sync u_sync (
            .clock  (clock),
            .reset_n(reset_n),
            .d      (ro_signal[i]),
            .q      (ro_sync_q[i])
        );
    end

    assign sample_bit = ^ro_sync_q;
    assign tick       = (state == SAMPLE) && (div_cnt == DIV_LAST);
    assign handshake  = rnd_valid && rnd_ready;
    // rep_cnt == 0 marks "no sample yet since warm-up", so the first sample counts as 1
    assign rep_next   = (rep_cnt != 8'd0 && sample_bit == last_bit) ? rep_cnt + 8'd1 : 8'd1;
    assign word_next  = {shift[WORD_WIDTH-2:0], sample_bit};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            ro_hold     <= '1;
            busy        <= 1'b0;
            health_fail <= 1'b0;
            rnd_data    <= '0;
            rnd_valid   <= 1'b0;
            warm_cnt    <= '0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            rep_cnt     <= '0;
            last_bit    <= 1'b0;
            shift       <= '0;
        end else begin
            // Consumed words drop valid unless a new word is loaded below
            if (handshake) rnd_valid <= 1'b0;

            if (stop && busy) begin
                state    <= IDLE;
                ro_hold  <= '1;
                busy     <= 1'b0;
                warm_cnt <= '0;
                div_cnt  <= '0;
                bit_cnt  <= '0;
                shift    <= '0;
            end else if (start && !stop) begin
                state       <= WARMUP;
                ro_hold     <= '0;
                busy        <= 1'b1;
                health_fail <= 1'b0;
                warm_cnt    <= WARM_INIT;
                div_cnt     <= '0;
                bit_cnt     <= '0;
                rep_cnt     <= '0;
                shift       <= '0;
            end else begin
                case (state)
                    WARMUP: begin
                        warm_cnt <= warm_cnt - 1'b1;
                        if (warm_cnt == WARM_LAST) begin
                            state   <= SAMPLE;
                            div_cnt <= '0;
                        end
                    end
                    SAMPLE: begin
                        div_cnt <= tick ? '0 : div_cnt + 1'b1;
                        if (tick) begin
                            if (rep_next == REP_LIM) begin
                                state       <= FAIL;
                                health_fail <= 1'b1;
                                ro_hold     <= '1;
                                busy        <= 1'b0;
                                rnd_valid   <= 1'b0;
                                bit_cnt     <= '0;
                                rep_cnt     <= '0;
                                shift       <= '0;
                            end else begin
                                shift    <= word_next;
                                rep_cnt  <= rep_next;
                                last_bit <= sample_bit;
                                if (bit_cnt == BIT_LAST) begin
                                    bit_cnt <= '0;
                                    if (!rnd_valid || rnd_ready) begin
                                        rnd_data  <= word_next;
                                        rnd_valid <= 1'b1;
                                    end else begin
                                        // Completed word parks in shift until the output frees up
                                        state <= HOLD;
                                    end
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                end
                            end
                        end
                    end
                    HOLD: begin
                        if (handshake) begin
                            rnd_data  <= shift;
                            rnd_valid <= 1'b1;
                            state     <= SAMPLE;
                            div_cnt   <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/ro_entropy_ctrl.md
# ro_entropy_ctrl

Controller that sequences a bank of free-running ring oscillators for the TRNG: it releases the rings, waits a warm-up period, then samples their XORed outputs at a fixed rate. Bits are packed into words and presented on a valid/ready port. The block runs a repetition-count health test and shuts the rings down on failure. It sits between the oscillator instances and the entropy consumer (conditioner/FIFO).

## Interface
- NUM_RO, 4: number of ring oscillators controlled (≥1)
- WARMUP_CYCLES, 64: clock cycles rings run before the first sample is kept (≥1)
- SAMPLE_DIV, 8: clock cycles between sample ticks (≥2)
- WORD_WIDTH, 32: bits per output word (≥2)
- REP_LIMIT, 32: consecutive identical samples that trip the health test (≥2, ≤255)

- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; begin or restart generation
- stop  in  1  pulse; halt generation
- ro_signal  in  NUM_RO  raw oscillator outputs, asynchronous to clock
- ro_hold  out  NUM_RO  drives each oscillator's enable input; 1 forces ring static, 0 lets it oscillate
- rnd_data  out  WORD_WIDTH  output word
- rnd_valid  out  1  rnd_data holds an unconsumed word
- rnd_ready  in  1  consumer accepts word
- busy  out  1  state is WARMUP, SAMPLE or HOLD
- health_fail  out  1  sticky health-test failure flag

## Operation
- Each ro_signal bit passes a 2-flop synchronizer; sample bit = XOR of all synchronized bits.
- States: IDLE, WARMUP, SAMPLE, HOLD, FAIL.
- IDLE: ro_hold all 1. start -> WARMUP, load warm-up counter with WARMUP_CYCLES, clear shift register, bit count, repetition counter, health_fail.
- WARMUP: ro_hold all 0; counter decrements each cycle; at 1 -> SAMPLE, clear sample divider.
- SAMPLE: divider counts 0..SAMPLE_DIV-1; tick when it reaches SAMPLE_DIV-1. On tick: shift register <= {shift[WORD_WIDTH-2:0], bit}; bit count +1; update health test.
- Word complete (WORD_WIDTH-th tick): if output register empty or handshake occurs this cycle, load rnd_data, assert rnd_valid, reset bit count, stay in SAMPLE; else -> HOLD.
- HOLD: rings keep running, no ticks; on handshake load completed word into rnd_data, rnd_valid stays 1, -> SAMPLE with divider cleared.
- Handshake: rnd_valid && rnd_ready at a rising edge; rnd_data stable while rnd_valid=1 and not accepted.
- Health test: counter of consecutive equal samples (first sample after WARMUP starts at 1). Reaching REP_LIMIT -> FAIL in the same edge: health_fail=1, ro_hold all 1, rnd_valid=0, partial word discarded.
- FAIL: stays until start (-> WARMUP) or reset. stop ignored.
- stop in WARMUP/SAMPLE/HOLD -> IDLE: ro_hold all 1, partial word discarded; a pending rnd_valid word remains until consumed.
- start while busy: restart into WARMUP, partial word discarded, pending output word retained.
- start and stop together: stop wins.

## Timing
- Reset values: ro_hold all 1, rnd_data 0, rnd_valid 0, busy 0, health_fail 0, state IDLE, all counters 0.
- start seen at edge N: ro_hold=0 and busy=1 after edge N; SAMPLE entered after edge N+WARMUP_CYCLES.
- First tick WARMUP_CYCLES+SAMPLE_DIV cycles after start edge; first rnd_valid asserted after edge N+WARMUP_CYCLES+WORD_WIDTH·SAMPLE_DIV.
- Sample bit reflects ro_signal 2 cycles before the tick (synchronizer latency).
- Throughput: one word per WORD_WIDTH·SAMPLE_DIV cycles with rnd_ready held 1.
- health_fail and FAIL entry take effect at the tick edge that reaches REP_LIMIT.

## Test plan
Parameters NUM_RO=2, WARMUP_CYCLES=4, SAMPLE_DIV=2, WORD_WIDTH=8, REP_LIMIT=5.
- Reset mid-operation (reset_n low during SAMPLE) -> all outputs at reset values immediately, asynchronously.
- start, ro_signal driven so XOR alternates 1,0 per tick, rnd_ready=1 -> rnd_data=8'hAA, rnd_valid first high 4+16 cycles after start, one word each 16 cycles.
- Same stimulus, rnd_ready=0 for 40 cycles -> first word held stable, state HOLD after second word completes, no ticks; rnd_ready=1 -> two consecutive words delivered, sampling resumes.
- XOR held at 1 -> after 5th tick health_fail=1, ro_hold=2'b11, rnd_valid=0; stop ignored; start -> health_fail=0, WARMUP.
- stop after 3 ticks -> IDLE, ro_hold=2'b11, busy=0, no word emitted; start and stop same cycle from IDLE -> stays IDLE.
